// File: rtl/popcount_acc_pipe.sv
// Streaming population counter: grouped partial counts, registered adder
// tree, and a per-word or saturating frame-accumulate output stage.
module popcount_acc_pipe #(
   parameter int WIDTH = 16,
   parameter int ACC_W = 16,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             out_last,
   output logic             out_ovf
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int NG = WIDTH / GROUP;
   localparam int GW = $clog2(GROUP + 1);

   if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
      $error("popcount_acc_pipe: WIDTH out of range");
   end
   if (ACC_W < CW) begin : g_bad_accw
      $error("popcount_acc_pipe: ACC_W narrower than count");
   end
   if (WIDTH % GROUP != 0) begin : g_bad_group
      $error("popcount_acc_pipe: GROUP must divide WIDTH");
   end

   typedef enum logic {
      IDLE,
      IN_FRAME
   } fstate_e;

   logic              stall;
   logic              adv;

   logic [GW-1:0]     part_d [NG];
   logic [GW-1:0]     part_q [NG];
   logic              v1_q;
   logic              last1_q;
   logic              mode1_q;

   logic [CW-1:0]     cnt2_d;
   logic [CW-1:0]     cnt2_q;
   logic              v2_q;
   logic              last2_q;
   logic              mode2_q;

   logic [ACC_W:0]    sum_w;
   logic              sat_w;
   logic [ACC_W-1:0]  acc_d;
   logic [ACC_W-1:0]  acc_q;
   logic              sticky_q;
   logic              eff_mode;
   fstate_e           state_q;
   logic              fmode_q;

   logic              out_valid_q;
   logic [ACC_W-1:0]  out_data_q;
   logic              out_last_q;
   logic              out_ovf_q;

   // Every stage freezes together while a result waits downstream.
   assign stall    = out_valid_q & ~out_ready;
   assign adv      = ~stall;
   assign in_ready = adv;

   always_comb begin
      for (int g = 0; g < NG; g++) begin
         part_d[g] = '0;
         for (int b = 0; b < GROUP; b++) begin
            part_d[g] = part_d[g] + GW'(in_data[g*GROUP+b]);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q    <= 1'b0;
         last1_q <= 1'b0;
         mode1_q <= 1'b0;
         for (int g = 0; g < NG; g++) begin
            part_q[g] <= '0;
         end
      end else if (adv) begin
         v1_q    <= in_valid;
         last1_q <= in_last;
         mode1_q <= mode;
         for (int g = 0; g < NG; g++) begin
            part_q[g] <= part_d[g];
         end
      end
   end

   always_comb begin
      cnt2_d = '0;
      for (int g = 0; g < NG; g++) begin
         cnt2_d = cnt2_d + CW'(part_q[g]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_q    <= 1'b0;
         last2_q <= 1'b0;
         mode2_q <= 1'b0;
         cnt2_q  <= '0;
      end else if (adv) begin
         v2_q    <= v1_q;
         last2_q <= last1_q;
         mode2_q <= mode1_q;
         cnt2_q  <= cnt2_d;
      end
   end

   // The mode travels with each word; only a frame's first word decides.
   assign eff_mode = (state_q == IDLE) ? mode2_q : fmode_q;
   assign sum_w    = {1'b0, acc_q} + (ACC_W+1)'(cnt2_q);
   assign sat_w    = sum_w[ACC_W];
   assign acc_d    = sat_w ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         fmode_q     <= 1'b0;
         acc_q       <= '0;
         sticky_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_ovf_q   <= 1'b0;
      end else if (adv) begin
         out_valid_q <= 1'b0;
         if (v2_q) begin
            fmode_q <= eff_mode;
            state_q <= last2_q ? IDLE : IN_FRAME;
            if (!eff_mode) begin
               out_valid_q <= 1'b1;
               out_data_q  <= ACC_W'(cnt2_q);
               out_last_q  <= last2_q;
               out_ovf_q   <= 1'b0;
            end else if (last2_q) begin
               out_valid_q <= 1'b1;
               out_data_q  <= acc_d;
               out_last_q  <= 1'b1;
               out_ovf_q   <= sticky_q | sat_w;
               acc_q       <= '0;
               sticky_q    <= 1'b0;
            end else begin
               acc_q       <= acc_d;
               sticky_q    <= sticky_q | sat_w;
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_popcount_acc_pipe.sv
// Bench for popcount_acc_pipe: two instances (ACC_W 16 and 8) share one
// stimulus stream and are checked against a frame-level reference model.
module tb_popcount_acc_pipe;

   logic        clk;
   logic        rst_n;
   logic        mode;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_last;
   logic        out_ready;

   logic        in_ready_a, out_valid_a, out_last_a, out_ovf_a;
   logic [15:0] out_data_a;
   logic        in_ready_b, out_valid_b, out_last_b, out_ovf_b;
   logic [7:0]  out_data_b;

   popcount_acc_pipe #(.WIDTH(16), .ACC_W(16), .GROUP(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .mode(mode),
      .in_valid(in_valid), .in_ready(in_ready_a),
      .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid_a), .out_ready(out_ready),
      .out_data(out_data_a), .out_last(out_last_a), .out_ovf(out_ovf_a)
   );

   popcount_acc_pipe #(.WIDTH(16), .ACC_W(8), .GROUP(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .mode(mode),
      .in_valid(in_valid), .in_ready(in_ready_b),
      .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid_b), .out_ready(out_ready),
      .out_data(out_data_b), .out_last(out_last_b), .out_ovf(out_ovf_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      longint total;
      bit     last;
      bit     m;
   } exp_t;

   exp_t   q[$];
   bit     inframe;
   bit     fm;
   longint tot;
   int     tests;
   int     fails;
   int     nout;
   longint last_a, last_b;
   longint lovf_a, lovf_b;
   bit     rnd_done;

   task automatic chk(input string tag, input longint obs, input longint exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint satv(input longint t, input longint mx);
      return (t > mx) ? mx : t;
   endfunction

   // Reference: frames are whole units; mode 1 emits min(sum, max) at last.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid_a && out_ready) begin
            nout++;
            last_a = out_data_a;
            last_b = out_data_b;
            lovf_a = out_ovf_a;
            lovf_b = out_ovf_b;
            if (q.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("data_a", out_data_a, e.m ? satv(e.total, 65535) : e.total);
               chk("last_a", out_last_a, e.last);
               chk("ovf_a", out_ovf_a, e.m && e.total > 65535);
               chk("valid_b", out_valid_b, 1);
               chk("ready_b", in_ready_b, 1);
               chk("data_b", out_data_b, e.m ? satv(e.total, 255) : e.total);
               chk("last_b", out_last_b, e.last);
               chk("ovf_b", out_ovf_b, e.m && e.total > 255);
            end
         end
         if (in_valid && in_ready_a) begin
            if (!inframe) begin
               inframe = 1'b1;
               fm      = mode;
               tot     = 0;
            end
            tot += $countones(in_data);
            if (!fm)
               q.push_back('{longint'($countones(in_data)), in_last, 1'b0});
            else if (in_last)
               q.push_back('{tot, 1'b1, 1'b1});
            if (in_last) inframe = 1'b0;
         end
      end
   end

   task automatic send(input logic [15:0] d, input logic l, input logic m);
      int k;
      in_data  = d;
      in_last  = l;
      mode     = m;
      in_valid = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!in_ready_a && k < 200);
      if (!in_ready_a) chk("in_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("drain_empty", q.size(), 0);
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      q.delete();
      inframe  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", out_valid_a, 0);
      chk("rst_data", out_data_a, 0);
      chk("rst_last", out_last_a, 0);
      chk("rst_ovf", out_ovf_a, 0);
      chk("rst_valid_b", out_valid_b, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready_a, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      logic [15:0] snap;
      tests = 0; fails = 0; nout = 0;
      mode = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      out_ready = 1'b1;
      do_reset();

      // Single word latency
      send(16'hFFFF, 1'b1, 1'b0);
      idle();
      @(negedge clk); chk("lat_c1", out_valid_a, 0);
      @(negedge clk); chk("lat_c2", out_valid_a, 0);
      @(negedge clk); chk("lat_c3", out_valid_a, 1);
      chk("ones_cnt", out_data_a, 16);
      chk("ones_last", out_last_a, 1);
      chk("ones_ovf", out_ovf_a, 0);
      @(posedge clk); #1;
      drain();

      // Back-to-back mode 0
      send(16'h0000, 1'b0, 1'b0);
      send(16'h8001, 1'b0, 1'b0);
      send(16'h0F0F, 1'b1, 1'b0);
      idle();
      @(negedge clk); chk("b2b_v0", out_valid_a, 1); chk("b2b_d0", out_data_a, 0);
      chk("b2b_r0", in_ready_a, 1);
      @(negedge clk); chk("b2b_v1", out_valid_a, 1); chk("b2b_d1", out_data_a, 2);
      chk("b2b_r1", in_ready_a, 1);
      @(negedge clk); chk("b2b_v2", out_valid_a, 1); chk("b2b_d2", out_data_a, 8);
      @(negedge clk); chk("b2b_end", out_valid_a, 0);
      @(posedge clk); #1;
      drain();

      // Mode 1 frame
      n0 = nout;
      send(16'h00FF, 1'b0, 1'b1);
      send(16'h0F0F, 1'b0, 1'b1);
      send(16'hFFFF, 1'b1, 1'b1);
      idle();
      drain();
      chk("frame_nout", nout - n0, 1);
      chk("frame_sum", last_a, 32);
      chk("frame_ovf", lovf_a, 0);

      // Saturation on the 8-bit accumulator
      for (int i = 0; i < 20; i++) send(16'hFFFF, i == 19, 1'b1);
      idle();
      drain();
      chk("sat_a", last_a, 320);
      chk("sat_a_ovf", lovf_a, 0);
      chk("sat_b", last_b, 255);
      chk("sat_b_ovf", lovf_b, 1);
      send(16'h0003, 1'b1, 1'b1);
      idle();
      drain();
      chk("after_sat_b", last_b, 2);
      chk("after_sat_ovf", lovf_b, 0);

      // Stall with held output
      n0 = nout;
      fork
         begin
            for (int i = 0; i < 6; i++) send(16'($urandom), i == 5, 1'b0);
            idle();
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            out_ready = 1'b0;
            @(negedge clk);
            snap = out_data_a;
            chk("stall_valid", out_valid_a, 1);
            chk("stall_ready", in_ready_a, 0);
            repeat (4) begin
               @(negedge clk);
               chk("stall_hold_v", out_valid_a, 1);
               chk("stall_hold_d", out_data_a, snap);
               chk("stall_ready", in_ready_a, 0);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
      chk("stall_nout", nout - n0, 6);

      // Reset mid-frame discards the frame
      send(16'h00F0, 1'b0, 1'b1);
      send(16'h0F00, 1'b0, 1'b1);
      idle();
      @(posedge clk); #1;
      do_reset();
      n0 = nout;
      send(16'h0001, 1'b1, 1'b1);
      idle();
      drain();
      chk("rst_frame_nout", nout - n0, 1);
      chk("rst_frame_sum", last_a, 1);

      // Randomized traffic with backpressure
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  idle();
                  @(posedge clk); #1;
               end
               send(($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom),
                    (i == 299) || ($urandom_range(0, 4) == 0),
                    1'($urandom_range(0, 1)));
            end
            idle();
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               out_ready = ($urandom_range(0, 3) != 0);
               @(posedge clk);
               #1;
            end
         end
      join
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
